// File: rtl/stack_unit.sv
// stack_unit: operand stack for the multicycle stack CPU.
// One command per cycle (push / pop / tos); pop and tos present the top word
// on the registered dout one cycle after the strobe. Illegal commands (more
// than one strobe, push while full, pop/tos while empty) leave all state alone.
// Optional feature: define STACK_UNIT_ERR_EN to build the sticky err register;
// otherwise err is tied low.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     tos,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] SP_ONE  = CW'(1);
    localparam logic [CW-1:0] SP_ZERO = '0;
    localparam logic [CW-1:0] SP_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] IX_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             multi;
    logic             do_push;
    logic             do_pop;
    logic             do_tos;

    // sp equals occupancy; status flags are decoded straight from it
    assign count   = sp;
    assign empty   = (sp == SP_ZERO);
    assign full    = (sp == SP_FULL);

    // sp < DEPTH whenever a push is allowed, so the low bits address the free slot;
    // the top word sits one below (wraps harmlessly when empty, never used then)
    assign wr_idx  = sp[AW-1:0];
    assign top_idx = sp[AW-1:0] - IX_ONE;

    // decode the strobes into exactly one legal action or nothing
    always_comb begin
        multi   = (push & pop) | (push & tos) | (pop & tos);
        do_push = push & ~multi & ~full;
        do_pop  = pop  & ~multi & ~empty;
        do_tos  = tos  & ~multi & ~empty;
    end

    // storage array: written only by a legal push, never reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    // stack pointer and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp   <= SP_ZERO;
            dout <= '0;
        end else begin
            if (do_push) begin
                sp <= sp + SP_ONE;
            end else if (do_pop) begin
                sp   <= sp - SP_ONE;
                dout <= mem[top_idx];
            end else if (do_tos) begin
                dout <= mem[top_idx];
            end
        end
    end

`ifdef STACK_UNIT_ERR_EN
    logic illegal;

    assign illegal = multi | (push & full) | (pop & empty) | (tos & empty);

    // sticky error: set by any illegal command, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit (DEPTH=4, WIDTH=8): directed scenarios plus randomized
// command stream, all checked against a queue-based stack model.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef STACK_UNIT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             tos = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             err;

    int total = 0;
    int bad   = 0;

    // reference model: a plain queue of words plus the read register and error flag
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_err;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
        .din(din), .dout(dout), .count(count), .empty(empty),
        .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_err  = 1'b0;
    endtask

    // apply one command to the model by the stack rules
    task automatic model_cmd(input bit p, input bit o, input bit t, input logic [WIDTH-1:0] d);
        int n;
        n = int'(p) + int'(o) + int'(t);
        if (n > 1) m_err = ERR_EN;
        else if (p) begin
            if (q.size() == DEPTH) m_err = ERR_EN;
            else q.push_back(d);
        end else if (o) begin
            if (q.size() == 0) m_err = ERR_EN;
            else m_dout = q.pop_back();
        end else if (t) begin
            if (q.size() == 0) m_err = ERR_EN;
            else m_dout = q[q.size()-1];
        end
    endtask

    // drive one cycle of command, then sample 1 time unit after the edge
    task automatic step(input bit p, input bit o, input bit t, input logic [WIDTH-1:0] d);
        push = p; pop = o; tos = t; din = d;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        model_cmd(p, o, t, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_order();
        logic [WIDTH-1:0] exp_pop [3];
        exp_pop[0] = 8'h33; exp_pop[1] = 8'h22; exp_pop[2] = 8'h11;
        do_reset();
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL order_push_holds_dout got=%h exp=00", dout); end
        step(0, 0, 1, 8'h00);
        total++; if (dout !== 8'h33) begin bad++; $display("FAIL order_tos_dout got=%h exp=33", dout); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL order_tos_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            total++; if (dout !== exp_pop[i]) begin bad++; $display("FAIL order_pop%0d_dout got=%h exp=%h", i, dout, exp_pop[i]); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%b exp=1", empty); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL order_err got=%b exp=0", err); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'hA0 + 8'(i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err_before got=%b exp=0", err); end
        step(1, 0, 0, 8'hFF);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_overflow_count got=%0d exp=4", count); end
        total++; if (err !== ERR_EN) begin bad++; $display("FAIL full_overflow_err got=%b exp=%b", err, ERR_EN); end
        step(0, 1, 0, 8'h00);
        total++; if (dout !== 8'hA3) begin bad++; $display("FAIL full_pop_dout got=%h exp=a3", dout); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    endtask

    task automatic test_empty();
        do_reset();
        step(0, 1, 0, 8'h00);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL empty_pop_dout got=%h exp=00", dout); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
        step(0, 0, 1, 8'h00);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL empty_tos_dout got=%h exp=00", dout); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_tos_count got=%0d exp=0", count); end
        total++; if (err !== ERR_EN) begin bad++; $display("FAIL empty_err got=%b exp=%b", err, ERR_EN); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, 0, 0, 8'h10);
        step(1, 0, 0, 8'h20);
        step(1, 1, 0, 8'h55);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", count); end
        total++; if (err !== ERR_EN) begin bad++; $display("FAIL simul_err got=%b exp=%b", err, ERR_EN); end
        step(0, 0, 1, 8'h00);
        total++; if (dout !== 8'h20) begin bad++; $display("FAIL simul_tos_dout got=%h exp=20", dout); end
        step(0, 1, 1, 8'h00);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_poptos_count got=%0d exp=2", count); end
        total++; if (dout !== 8'h20) begin bad++; $display("FAIL simul_poptos_dout got=%h exp=20", dout); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        step(0, 0, 1, 8'h00);
        total++; if (dout !== 8'h02) begin bad++; $display("FAIL async_pre_dout got=%h exp=02", dout); end
        // assert reset between edges and look before any edge arrives
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", count); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL async_dout got=%h exp=00", dout); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_empty got=%b exp=1", empty); end
        // a command pending while reset is held has no effect
        push = 1'b1; din = 8'h77;
        @(posedge clk); #1;
        push = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL async_pending_count got=%0d exp=0", count); end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit p, o, t;
        int r;
        logic [WIDTH-1:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            d = WIDTH'($urandom);
            p = 0; o = 0; t = 0;
            if (r < 4) p = 1;
            else if (r < 6) o = 1;
            else if (r < 8) t = 1;
            else if (r < 10) begin
                p = 0;
            end else begin
                p = 1'($urandom); o = 1'($urandom); t = 1'($urandom);
            end
            step(p, o, t, d);
            total++; if (count !== 3'(q.size())) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", i, count, q.size()); end
            total++; if (dout !== m_dout) begin bad++; $display("FAIL rand%0d_dout got=%h exp=%h", i, dout, m_dout); end
            total++; if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rand%0d_empty got=%b exp=%b", i, empty, q.size() == 0); end
            total++; if (full !== (q.size() == DEPTH)) begin bad++; $display("FAIL rand%0d_full got=%b exp=%b", i, full, q.size() == DEPTH); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rand%0d_err got=%b exp=%b", i, err, m_err); end
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_order();
        test_full();
        test_empty();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
